// File: rtl/frame_serializer_tx.sv
// Word-to-serial frame transmitter: start bit, WIDTH data bits LSB first, stop bit.
// Define FRAME_SERIALIZER_TX_PARITY_EN to insert an even-parity bit between data and stop.
module frame_serializer_tx #(
  parameter int unsigned      WIDTH        = 8,
  parameter int unsigned      DIV          = 4,
  parameter logic [WIDTH-1:0] DEFAULT_WORD = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_data_en,
  output logic             o_serial,
  output logic             o_busy,
  output logic             o_done
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  // Counter value one cycle before the last cycle of a bit; only meaningful for DIV > 1.
  localparam logic [CW-1:0] DIV_PEN  = (DIV > 1) ? CW'(DIV - 2) : CW'(0);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic          ONE_CYC  = (DIV == 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef FRAME_SERIALIZER_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t           state;
  logic [CW-1:0]    div_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] sel_word;
  logic             div_tick;
`ifdef FRAME_SERIALIZER_TX_PARITY_EN
  logic             parity_bit;
`endif

  assign sel_word = i_data_en ? i_data : DEFAULT_WORD;
  assign div_tick = (div_cnt == DIV_LAST);

  // Frame sequencer; every output is a register updated one edge ahead of its cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
`ifdef FRAME_SERIALIZER_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
      o_serial   <= 1'b1;
      o_ready    <= 1'b1;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_valid && o_ready) begin
            state      <= S_START;
            shreg      <= sel_word;
`ifdef FRAME_SERIALIZER_TX_PARITY_EN
            parity_bit <= ^sel_word;
`endif
            div_cnt    <= '0;
            bit_cnt    <= '0;
            o_serial   <= 1'b0;
            o_ready    <= 1'b0;
            o_busy     <= 1'b1;
          end
        end

        S_START: begin
          if (div_tick) begin
            div_cnt  <= '0;
            state    <= S_DATA;
            o_serial <= shreg[0];
            shreg    <= shreg >> 1;
          end else begin
            div_cnt <= div_cnt + CW'(1);
          end
        end

        S_DATA: begin
          if (div_tick) begin
            div_cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
              bit_cnt  <= '0;
`ifdef FRAME_SERIALIZER_TX_PARITY_EN
              state    <= S_PARITY;
              o_serial <= parity_bit;
`else
              state    <= S_STOP;
              o_serial <= 1'b1;
              o_done   <= ONE_CYC;
`endif
            end else begin
              bit_cnt  <= bit_cnt + BW'(1);
              o_serial <= shreg[0];
              shreg    <= shreg >> 1;
            end
          end else begin
            div_cnt <= div_cnt + CW'(1);
          end
        end

`ifdef FRAME_SERIALIZER_TX_PARITY_EN
        S_PARITY: begin
          if (div_tick) begin
            div_cnt  <= '0;
            state    <= S_STOP;
            o_serial <= 1'b1;
            o_done   <= ONE_CYC;
          end else begin
            div_cnt <= div_cnt + CW'(1);
          end
        end
`endif

        S_STOP: begin
          if (div_tick) begin
            div_cnt <= '0;
            state   <= S_IDLE;
            o_ready <= 1'b1;
            o_busy  <= 1'b0;
          end else begin
            div_cnt <= div_cnt + CW'(1);
            // Raise done so it lands on the final stop cycle.
            if ((DIV > 1) && (div_cnt == DIV_PEN)) begin
              o_done <= 1'b1;
            end
          end
        end

        default: begin
          state    <= S_IDLE;
          div_cnt  <= '0;
          bit_cnt  <= '0;
          o_serial <= 1'b1;
          o_ready  <= 1'b1;
          o_busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_serializer_tx.sv
// Self-checking bench for frame_serializer_tx: queue-based frame model plus literal frame checks.
module tb_frame_serializer_tx;

  localparam int W    = 8;
  localparam int DIVA = 4;
  localparam int DIVB = 1;
  localparam logic [7:0] DEF = 8'h3C;
`ifdef FRAME_SERIALIZER_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NBITS = W + 2 + PB;
  localparam int FLA   = NBITS * DIVA;

  logic clk, rst_n;
  logic va, ea, vb, eb;
  logic [7:0] da, db;
  logic ready_a, serial_a, busy_a, done_a;
  logic ready_b, serial_b, busy_b, done_b;

  int n_cmp = 0;
  int n_bad = 0;

  frame_serializer_tx #(.WIDTH(W), .DIV(DIVA), .DEFAULT_WORD(DEF)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(va), .o_ready(ready_a), .i_data(da),
    .i_data_en(ea), .o_serial(serial_a), .o_busy(busy_a), .o_done(done_a));

  frame_serializer_tx #(.WIDTH(W), .DIV(DIVB), .DEFAULT_WORD(DEF)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(vb), .o_ready(ready_b), .i_data(db),
    .i_data_en(eb), .o_serial(serial_b), .o_busy(busy_b), .o_done(done_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got timeout, expected event", name);
  endtask

  // Model: one queue entry per future cycle, {serial, busy, done, ready}.
  logic [3:0] qa[$];
  logic [3:0] qb[$];

  function automatic logic frame_bit(input logic [7:0] w, input int i);
    if (i == 0) return 1'b0;
    if (i <= W) return w[i-1];
    if (PB == 1 && i == W + 1) return ^w;
    return 1'b1;
  endfunction

  task automatic push_frame(input int inst, input logic [7:0] w, input int div);
    int len;
    len = NBITS * div;
    for (int i = 0; i < len; i++) begin
      if (inst == 0) qa.push_back({frame_bit(w, i / div), 1'b1, (i == len - 1), 1'b0});
      else           qb.push_back({frame_bit(w, i / div), 1'b1, (i == len - 1), 1'b0});
    end
  endtask

  task automatic model_step();
    bit acc_a, acc_b;
    acc_a = (qa.size() == 0) && va;
    acc_b = (qb.size() == 0) && vb;
    if (qa.size() != 0) void'(qa.pop_front());
    if (qb.size() != 0) void'(qb.pop_front());
    if (acc_a) push_frame(0, ea ? da : DEF, DIVA);
    if (acc_b) push_frame(1, eb ? db : DEF, DIVB);
  endtask

  task automatic model_reset();
    qa.delete();
    qb.delete();
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      check("cycle_a", {serial_a, busy_a, done_a, ready_a}, (qa.size() != 0) ? qa[0] : 4'b1001);
      check("cycle_b", {serial_b, busy_b, done_b, ready_b}, (qb.size() != 0) ? qb[0] : 4'b1001);
    end
  end

  logic ta_s[0:127], ta_b[0:127], ta_d[0:127];
  logic tb_s[0:127], tb_d[0:127];

  task automatic wait_idle_a();
    int n;
    n = 0;
    while (!(ready_a && qa.size() == 0)) begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        timeout_fail("idle_wait_a");
        return;
      end
    end
  endtask

  task automatic wait_idle_b();
    int n;
    n = 0;
    while (!(ready_b && qb.size() == 0)) begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        timeout_fail("idle_wait_b");
        return;
      end
    end
  endtask

  // Send one word on instance A and record ncyc cycles; inputs are scrambled while busy.
  task automatic send_trace_a(input logic [7:0] d, input logic en, input int ncyc);
    wait_idle_a();
    va = 1'b1;
    da = d;
    ea = en;
    @(negedge clk);
    va = 1'b0;
    check("model_len_a", qa.size(), FLA);
    check("model_first_a", qa[0], 4'b0100);
    for (int c = 1; c <= ncyc; c++) begin
      ta_s[c] = serial_a;
      ta_b[c] = busy_a;
      ta_d[c] = done_a;
      if (c < ncyc) begin
        @(negedge clk);
        da = 8'($urandom);
        ea = 1'($urandom);
        va = 1'($urandom);
        if (c >= FLA - 1) va = 1'b0;
      end
    end
  endtask

  task automatic check_trace_a(input string tag, input int lit[$]);
    int act, exp, nbusy, ndone, first_done;
    for (int k = 0; k < NBITS; k++) begin
      act = 0;
      for (int j = 0; j < DIVA; j++) if (ta_s[1 + k * DIVA + j]) act = act | (1 << j);
      exp = (lit[k] != 0) ? ((1 << DIVA) - 1) : 0;
      check($sformatf("%s_bit%0d", tag, k), act, exp);
    end
    nbusy = 0;
    ndone = 0;
    first_done = -1;
    for (int c = 1; c <= FLA + 4; c++) begin
      if (ta_b[c]) nbusy++;
      if (ta_d[c]) begin
        ndone++;
        if (first_done < 0) first_done = c;
      end
    end
    check({tag, "_busy_cycles"}, nbusy, FLA);
    check({tag, "_done_cycle"}, first_done, FLA);
    check({tag, "_done_count"}, ndone, 1);
  endtask

  int lit_a5[$], lit_def[$], lit_5a[$], lit_07[$];
  int cnt, first_done, start2;
  logic [7:0] byte_act;

  initial begin
`ifdef FRAME_SERIALIZER_TX_PARITY_EN
    lit_a5  = '{0, 1,0,1,0,0,1,0,1, 0, 1};
    lit_def = '{0, 0,0,1,1,1,1,0,0, 0, 1};
    lit_5a  = '{0, 0,1,0,1,1,0,1,0, 0, 1};
    lit_07  = '{0, 1,1,1,0,0,0,0,0, 1, 1};
`else
    lit_a5  = '{0, 1,0,1,0,0,1,0,1, 1};
    lit_def = '{0, 0,0,1,1,1,1,0,0, 1};
    lit_5a  = '{0, 0,1,0,1,1,0,1,0, 1};
    lit_07  = '{0, 1,1,1,0,0,0,0,0, 1};
`endif
    rst_n = 1'b0;
    va = 1'b0; ea = 1'b0; da = 8'h00;
    vb = 1'b0; eb = 1'b0; db = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_a", {serial_a, busy_a, done_a, ready_a}, 4'b1001);
    check("reset_b", {serial_b, busy_b, done_b, ready_b}, 4'b1001);
    rst_n = 1'b1;
    @(negedge clk);

    send_trace_a(8'hA5, 1'b1, FLA + 4);
    check_trace_a("a5", lit_a5);

    send_trace_a(8'hFF, 1'b0, FLA + 4);
    check_trace_a("default_word", lit_def);

    send_trace_a(8'h07, 1'b1, FLA + 4);
    check_trace_a("w07", lit_07);

    // Abort a frame with an asynchronous reset in its 15th cycle.
    wait_idle_a();
    va = 1'b1; da = 8'hC3; ea = 1'b1;
    @(negedge clk);
    va = 1'b0;
    repeat (14) @(negedge clk);
    check("pre_reset_busy", busy_a, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_serial", serial_a, 1'b1);
    check("async_reset_ready", ready_a, 1'b1);
    check("async_reset_busy", busy_a, 1'b0);
    check("async_reset_done", done_a, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < FLA; c++) begin
      @(negedge clk);
      if (done_a) cnt++;
    end
    check("no_done_after_abort", cnt, 0);
    send_trace_a(8'h5A, 1'b1, FLA + 4);
    check_trace_a("after_reset", lit_5a);

    // Back-to-back words at one bit per cycle with valid held high.
    wait_idle_b();
    vb = 1'b1; db = 8'h96; eb = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      tb_s[c] = serial_b;
      tb_d[c] = done_b;
      if (c == 1) db = 8'h3B;
      if (c == NBITS + 2) vb = 1'b0;
    end
    first_done = -1;
    start2 = -1;
    for (int c = 1; c <= 40; c++) begin
      if (first_done < 0 && tb_d[c]) first_done = c;
      else if (first_done > 0 && start2 < 0 && !tb_s[c]) start2 = c;
    end
    check("b2b_first_done", first_done, NBITS);
    check("b2b_second_start", start2, NBITS + 2);
    check("b2b_gap_idle", tb_s[NBITS + 1], 1'b1);
    for (int i = 0; i < 8; i++) byte_act[i] = tb_s[2 + i];
    check("b2b_frame1_data", byte_act, 8'h96);
    for (int i = 0; i < 8; i++) byte_act[i] = tb_s[NBITS + 3 + i];
    check("b2b_frame2_data", byte_act, 8'h3B);

    // Random traffic on both instances; the model predicts every cycle.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      va = (($urandom % 3) != 0);
      da = 8'($urandom);
      ea = 1'($urandom);
      vb = (($urandom % 3) != 0);
      db = 8'($urandom);
      eb = 1'($urandom);
    end
    va = 1'b0;
    vb = 1'b0;
    repeat (FLA + 8) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
